// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, instruction memory and the decoder.
// master = fetch engine side, slave = memory/decoder/branch-resolution side.
interface fetch_sequencer_if #(
    parameter int IW  = 32,
    parameter int AW  = 64,
    parameter int OCW = 3
) ();

    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;

    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;

    logic          redirect_en;
    logic [AW-1:0] redirect_pc;

    logic           halted;
    logic [OCW-1:0] occupancy;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr_out,
        output instr_pc,
        input  instr_ready,
        input  redirect_en,
        input  redirect_pc,
        output halted,
        output occupancy
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr_out,
        input  instr_pc,
        output instr_ready,
        output redirect_en,
        output redirect_pc,
        input  halted,
        input  occupancy
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Pipelined instruction fetch engine: keeps up to MAX_OS memory requests in flight and
// buffers returned words with their PC in an in-order queue feeding the decoder.
module fetch_sequencer #(
    parameter int          IW       = 32,
    parameter int          AW       = 64,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OS   = 2,
    parameter logic [AW-1:0] RESET_PC = 64'h8000_0000
) (
    input logic            clk,
    input logic            rstn,
    fetch_sequencer_if.master bus
);

    localparam int PW  = $clog2(DEPTH);
    localparam int OCW = PW + 1;
    localparam int OSW = $clog2(MAX_OS + 1);
    localparam logic [IW-1:0] EBREAK = IW'(32'h0010_0073);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic [OCW-1:0]  count_q, count_d;
    logic [OSW-1:0]  os_q, os_d;
    logic [OSW-1:0]  drop_q, drop_d;
    logic [IW-1:0]   data_q [DEPTH];
    logic [IW-1:0]   data_d [DEPTH];
    logic [AW-1:0]   tag_q  [DEPTH];
    logic [AW-1:0]   tag_d  [DEPTH];
    logic [DEPTH-1:0] full_q, full_d;

    logic req_valid;
    logic req_fire;
    logic rsp_fire;
    logic instr_valid;
    logic issue_fire;
    logic halt_now;
    logic redirect_take;

    assign req_valid   = (state_q == RUN) && (count_q < OCW'(DEPTH)) && (os_q < OSW'(MAX_OS));
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign rsp_fire    = bus.imem_rsp_valid;
    assign instr_valid = (state_q == RUN) && full_q[head_q];
    assign issue_fire  = instr_valid && bus.instr_ready;
    assign halt_now    = issue_fire && (data_q[head_q] == EBREAK);
    // An ebreak leaving the queue wins over a redirect in the same cycle.
    assign redirect_take = (state_q == RUN) && bus.redirect_en && !halt_now;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = req_valid ? pc_q : '0;
    assign bus.instr_valid    = instr_valid;
    assign bus.instr_out      = instr_valid ? data_q[head_q] : '0;
    assign bus.instr_pc       = instr_valid ? tag_q[head_q] : '0;
    assign bus.halted         = (state_q == HALT);
    assign bus.occupancy      = count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (halt_now) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Outstanding count includes requests whose responses will be thrown away.
    always_comb begin
        os_d = os_q;
        if (req_fire && !rsp_fire) begin
            os_d = os_q + OSW'(1);
        end else if (!req_fire && rsp_fire && (os_q != '0)) begin
            os_d = os_q - OSW'(1);
        end
    end

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q;
        count_d = count_q;
        drop_d  = drop_q;
        data_d  = data_q;
        tag_d   = tag_q;
        full_d  = full_q;

        if (redirect_take) begin
            // Everything in flight, including this cycle's handshakes, becomes stale.
            pc_d    = bus.redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            count_d = '0;
            full_d  = '0;
            drop_d  = os_d;
        end else begin
            if (req_fire) begin
                pc_d           = pc_q + AW'(4);
                tag_d[tail_q]  = pc_q;
                full_d[tail_q] = 1'b0;
                tail_d         = tail_q + PW'(1);
            end

            if (rsp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - OSW'(1);
                end else if (state_q == RUN) begin
                    data_d[fill_q] = bus.imem_rsp_data;
                    full_d[fill_q] = 1'b1;
                    fill_d         = fill_q + PW'(1);
                end
            end

            if (issue_fire) begin
                full_d[head_q] = 1'b0;
                head_d         = head_q + PW'(1);
            end

            if (req_fire && !issue_fire) begin
                count_d = count_q + OCW'(1);
            end else if (!req_fire && issue_fire) begin
                count_d = count_q - OCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            os_q    <= '0;
            drop_q  <= '0;
            full_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            os_q    <= os_d;
            drop_q  <= drop_d;
            full_q  <= full_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle-vector table for streaming/back-pressure,
// then hand-written sequences against a small in-order memory model.
module tb_fetch_sequencer;

    localparam int IW     = 32;
    localparam int AW     = 64;
    localparam int DEPTH  = 4;
    localparam int MAX_OS = 2;
    localparam int OCW    = 3;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.IW(IW), .AW(AW), .OCW(OCW)) bus ();

    fetch_sequencer #(
        .IW(IW), .AW(AW), .DEPTH(DEPTH), .MAX_OS(MAX_OS), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    typedef struct {
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        instr_ready;
        logic        exp_req_valid;
        logic [63:0] exp_req_addr;
        logic        exp_instr_valid;
        logic [31:0] exp_instr_out;
        logic [63:0] exp_instr_pc;
        logic [2:0]  exp_occ;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t        vecs [17];
    pend_t       pend [$];
    int          cyc;
    int          lat;
    int          issued;
    logic [63:0] exp_pc;
    logic [63:0] ebreak_addr;
    logic        hold_pending;
    logic [63:0] hold_addr;

    logic        s_rv, s_iv, s_halt;
    logic [63:0] s_ra, s_ip;
    logic [31:0] s_io;
    logic [2:0]  s_occ;

    function automatic vec_t mk(logic rr, logic rv, logic [31:0] rd, logic ir, logic erv,
                                logic [63:0] era, logic eiv, logic [31:0] eio,
                                logic [63:0] eip, logic [2:0] eocc);
        vec_t v;
        v.req_ready = rr;  v.rsp_valid = rv;  v.rsp_data = rd;  v.instr_ready = ir;
        v.exp_req_valid = erv;  v.exp_req_addr = era;  v.exp_instr_valid = eiv;
        v.exp_instr_out = eio;  v.exp_instr_pc = eip;  v.exp_occ = eocc;
        return v;
    endfunction

    function automatic logic [31:0] word_for(logic [63:0] a);
        if (a == ebreak_addr) return 32'h0010_0073;
        return {16'h1300, a[15:0]};
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample_outputs();
        s_rv   = bus.imem_req_valid;
        s_ra   = bus.imem_req_addr;
        s_iv   = bus.instr_valid;
        s_io   = bus.instr_out;
        s_ip   = bus.instr_pc;
        s_halt = bus.halted;
        s_occ  = bus.occupancy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_en    = 1'b0;
        bus.redirect_pc    = '0;
        #1;
        sample_outputs();
        check_eq("rst_req_valid", 64'(s_rv), 64'd0);
        check_eq("rst_req_addr", s_ra, 64'd0);
        check_eq("rst_instr_valid", 64'(s_iv), 64'd0);
        check_eq("rst_halted", 64'(s_halt), 64'd0);
        check_eq("rst_occupancy", 64'(s_occ), 64'd0);
        repeat (2) @(posedge clk);
        pend.delete();
        hold_pending = 1'b0;
        exp_pc = RESET_PC;
        issued = 0;
        cyc = 0;
        @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        bus.imem_req_ready = v.req_ready;
        bus.imem_rsp_valid = v.rsp_valid;
        bus.imem_rsp_data  = v.rsp_data;
        bus.instr_ready    = v.instr_ready;
        bus.redirect_en    = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        #1;
        sample_outputs();
        check_eq($sformatf("vec%0d.req_valid", idx), 64'(s_rv), 64'(v.exp_req_valid));
        check_eq($sformatf("vec%0d.req_addr", idx), s_ra, v.exp_req_addr);
        check_eq($sformatf("vec%0d.instr_valid", idx), 64'(s_iv), 64'(v.exp_instr_valid));
        check_eq($sformatf("vec%0d.instr_out", idx), 64'(s_io), 64'(v.exp_instr_out));
        check_eq($sformatf("vec%0d.instr_pc", idx), s_ip, v.exp_instr_pc);
        check_eq($sformatf("vec%0d.occupancy", idx), 64'(s_occ), 64'(v.exp_occ));
        check_eq($sformatf("vec%0d.halted", idx), 64'(s_halt), 64'd0);
    endtask

    // One clock of the memory model: in-order responses 'lat' cycles after acceptance.
    task automatic run_cycle(input logic rr, input logic ir, input logic red, input logic [63:0] rpc);
        int os_now;
        @(negedge clk);
        bus.imem_req_ready = rr;
        bus.instr_ready    = ir;
        bus.redirect_en    = red;
        bus.redirect_pc    = rpc;
        os_now = pend.size();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_for(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
        sample_outputs();
        check_eq("os_bound", 64'(os_now <= MAX_OS), 64'd1);
        if (s_rv) check_eq("req_with_os_room", 64'(os_now < MAX_OS), 64'd1);
        if (hold_pending && !s_halt) begin
            check_eq("req_valid_held", 64'(s_rv), 64'd1);
            check_eq("req_addr_stable", s_ra, hold_addr);
        end
        if (s_iv && ir) begin
            check_eq("issue_pc", s_ip, exp_pc);
            check_eq("issue_word", 64'(s_io), 64'(word_for(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            issued++;
        end
        if (red && !s_halt) exp_pc = rpc;
        @(posedge clk);
        if (s_rv && rr) pend.push_back('{addr: s_ra, due: cyc + lat});
        hold_pending = s_rv && !rr && !red;
        hold_addr    = s_ra;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ebreak_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
        hold_pending = 1'b0;
        hold_addr    = '0;
        lat          = 1;
        cyc          = 0;
        issued       = 0;
        exp_pc       = RESET_PC;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_en    = 1'b0;
        bus.redirect_pc    = '0;

        // Streaming with 1-cycle memory, then decoder stall until full, one freed slot, drain.
        vecs[0]  = mk(1, 0, 32'h0,          1, 0, 64'h0,           0, 32'h0,          64'h0,           3'd0);
        vecs[1]  = mk(1, 0, 32'h0,          1, 1, 64'h8000_0000,   0, 32'h0,          64'h0,           3'd0);
        vecs[2]  = mk(1, 1, 32'h1300_0000,  1, 1, 64'h8000_0004,   0, 32'h0,          64'h0,           3'd1);
        vecs[3]  = mk(1, 1, 32'h1300_0004,  1, 1, 64'h8000_0008,   1, 32'h1300_0000,  64'h8000_0000,   3'd2);
        vecs[4]  = mk(1, 1, 32'h1300_0008,  1, 1, 64'h8000_000C,   1, 32'h1300_0004,  64'h8000_0004,   3'd2);
        vecs[5]  = mk(1, 1, 32'h1300_000C,  1, 1, 64'h8000_0010,   1, 32'h1300_0008,  64'h8000_0008,   3'd2);
        vecs[6]  = mk(1, 1, 32'h1300_0010,  0, 1, 64'h8000_0014,   1, 32'h1300_000C,  64'h8000_000C,   3'd2);
        vecs[7]  = mk(1, 1, 32'h1300_0014,  0, 1, 64'h8000_0018,   1, 32'h1300_000C,  64'h8000_000C,   3'd3);
        vecs[8]  = mk(1, 1, 32'h1300_0018,  0, 0, 64'h0,           1, 32'h1300_000C,  64'h8000_000C,   3'd4);
        vecs[9]  = mk(1, 0, 32'h0,          1, 0, 64'h0,           1, 32'h1300_000C,  64'h8000_000C,   3'd4);
        vecs[10] = mk(1, 0, 32'h0,          0, 1, 64'h8000_001C,   1, 32'h1300_0010,  64'h8000_0010,   3'd3);
        vecs[11] = mk(1, 1, 32'h1300_001C,  0, 0, 64'h0,           1, 32'h1300_0010,  64'h8000_0010,   3'd4);
        vecs[12] = mk(0, 0, 32'h0,          1, 0, 64'h0,           1, 32'h1300_0010,  64'h8000_0010,   3'd4);
        vecs[13] = mk(0, 0, 32'h0,          1, 1, 64'h8000_0020,   1, 32'h1300_0014,  64'h8000_0014,   3'd3);
        vecs[14] = mk(0, 0, 32'h0,          1, 1, 64'h8000_0020,   1, 32'h1300_0018,  64'h8000_0018,   3'd2);
        vecs[15] = mk(0, 0, 32'h0,          1, 1, 64'h8000_0020,   1, 32'h1300_001C,  64'h8000_001C,   3'd1);
        vecs[16] = mk(0, 0, 32'h0,          0, 1, 64'h8000_0020,   0, 32'h0,          64'h0,           3'd0);

        $display("[TB] table: streaming and back-pressure");
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i]);
            check_output(i, vecs[i]);
        end

        $display("[TB] sequence: latency 5 with intermittent req_ready");
        lat = 5;
        do_reset();
        for (int i = 0; i < 40; i++) run_cycle((i % 3) != 1, 1'b1, 1'b0, 64'h0);
        check_eq("lat5_throughput", 64'(issued >= 8), 64'd1);

        $display("[TB] sequence: redirect with two responses in flight");
        lat = 3;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_cycle(1'b1, 1'b1, i == 3, 64'h8000_0100);
            if (i == 3) begin
                check_eq("redir_os_full_no_req", 64'(s_rv), 64'd0);
                issued = 0;
            end
            if (i == 4) check_eq("redir_occ_cleared", 64'(s_occ), 64'd0);
        end
        check_eq("redir_issued_after", 64'(issued >= 3), 64'd1);

        $display("[TB] sequence: redirect coinciding with request and response");
        lat = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b1, 1'b1, i == 2, 64'h8000_0200);
            if (i == 2) begin
                check_eq("coinc_req_valid", 64'(s_rv), 64'd1);
                check_eq("coinc_req_addr", s_ra, 64'h8000_0004);
                issued = 0;
            end
            if (i == 3) begin
                check_eq("coinc_occ_cleared", 64'(s_occ), 64'd0);
                check_eq("coinc_new_addr", s_ra, 64'h8000_0200);
            end
        end
        check_eq("coinc_issued_after", 64'(issued >= 3), 64'd1);

        $display("[TB] sequence: ebreak halt");
        ebreak_addr = 64'h8000_0000;
        lat = 3;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            run_cycle(1'b1, 1'b1, i == 7, 64'h8000_0300);
            if (i == 5) begin
                check_eq("halt_pre_halted", 64'(s_halt), 64'd0);
                check_eq("halt_ebreak_valid", 64'(s_iv), 64'd1);
                check_eq("halt_ebreak_word", 64'(s_io), 64'h0010_0073);
                check_eq("halt_req_outstanding", 64'(s_rv), 64'd1);
            end
            if (i >= 6) begin
                check_eq("halt_halted", 64'(s_halt), 64'd1);
                check_eq("halt_no_req", 64'(s_rv), 64'd0);
                check_eq("halt_no_instr", 64'(s_iv), 64'd0);
            end
        end
        ebreak_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        lat = 1;
        do_reset();
        for (int i = 0; i < 2; i++) run_cycle(1'b1, 1'b0, 1'b0, 64'h0);
        check_eq("post_halt_reset_addr", s_ra, RESET_PC);
        check_eq("post_halt_reset_halted", 64'(s_halt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised successor to the core's single-instruction fetch/latch controller; replaces the IDLE/FETCH/WAIT/EXEC one-at-a-time loop with a pipelined fetch engine.
- Keeps up to MAX_OS instruction-memory requests in flight over valid/ready handshakes and buffers returned words, each tagged with its PC, in a DEPTH-entry in-order queue.
- Presents instructions to the decoder through a valid/ready handshake and supports PC redirect (flush) from branch/jump resolution.
- Halts on an issued ebreak.

Parameters:
- IW, 32, instruction width.
- AW, 64, PC/address width.
- DEPTH, 4, queue entries; power of two, >=2.
- MAX_OS, 2, max outstanding memory requests, including ones to be discarded; 1..DEPTH.
- RESET_PC, 64'h8000_0000, first fetch address.

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  AW  fetch address.
- imem_rsp_valid  in  1  response word valid; responses return in request order; no back-pressure.
- imem_rsp_data  in  IW  instruction word.
- instr_valid  out  1  head instruction available.
- instr_ready  in  1  decoder consumes head.
- instr_out  out  IW  head instruction.
- instr_pc  out  AW  PC of head instruction.
- redirect_en  in  1  one-cycle flush request.
- redirect_pc  in  AW  new fetch PC.
- halted  out  1  ebreak issued; fetch stopped.
- occupancy  out  $clog2(DEPTH)+1  allocated queue slots.

Behaviour:
- Reset, async on rstn low:
  - All outputs 0; occupancy 0.
  - pc=RESET_PC; pointers, counters and drop_cnt cleared; state IDLE.
  - Reset mid-transaction abandons everything; responses for pre-reset requests are not expected.
- States:
  - IDLE: unconditional advance to RUN next cycle.
  - RUN: normal operation.
  - HALT: terminal; left only by reset.
- Request issue:
  - imem_req_valid=1 in RUN iff occupancy<DEPTH and os_total<MAX_OS; imem_req_addr=pc.
  - On req fire: pc+=4 (mod 2^AW, wrap allowed); slot allocated at tail with pc tag, marked empty; os_total+1.
  - Valid/addr stay stable until accepted, except across a redirect cycle (request withdrawn, new addr next cycle).
- Response:
  - On rsp fire, os_total-1.
  - If drop_cnt>0: word discarded, drop_cnt-1.
  - Otherwise: word written into oldest empty allocated slot, which is marked full.
- Issue:
  - instr_valid=1 iff head slot full and state RUN; instr_out/instr_pc come from the head slot, combinationally from registers.
  - On valid&ready: head freed, occupancy-1.
  - Zero bubble: an entry filled in cycle N is visible in cycle N+1.
- Redirect (redirect_en=1, RUN only):
  - Queue cleared: occupancy 0, pointers reset.
  - pc<=redirect_pc.
  - drop_cnt<=os_total + req_fire - rsp_fire, where those are this cycle's handshakes; a response arriving this cycle is discarded.
  - instr issue in the redirect cycle is still honoured if valid&ready.
  - Fetch resumes next cycle; new responses fill only after drop_cnt reaches 0.
- Halt:
  - Issuing instr_out==32'h0010_0073 (ebreak) moves to HALT next cycle.
  - In HALT: halted=1; req_valid=0; instr_valid=0; redirect ignored.
  - Remaining responses are absorbed and discarded; os_total still decrements.
- Simultaneous events:
  - Fire and issue in the same cycle leave occupancy unchanged.
  - Redirect takes priority over allocate and fill.
  - Halt takes priority over redirect when both occur in the same cycle.
- Full: no request while occupancy==DEPTH. Empty: instr_valid=0.
- Counters never overflow: os_total<=MAX_OS; drop_cnt<=MAX_OS.

Test Plan:
- Reset then imem_req_ready=1, 1-cycle-latency memory, instr_ready=1 -> request addrs 8000_0000, 8000_0004, ... after IDLE cycle; steady one instruction/cycle; instr_pc matches.
- instr_ready=0 with DEPTH=4 -> exactly 4 requests; occupancy=4; req_valid=0 until one issue frees a slot, then exactly one new request.
- Memory latency 5, MAX_OS=2 -> never more than 2 unanswered requests; req_valid held with stable addr while imem_req_ready=0.
- Redirect to 8000_0100 with 2 responses in flight -> those 2 words discarded; next issued instr_pc=8000_0100; occupancy 0 in the cycle after redirect.
- Redirect coinciding with rsp fire and req fire (os_total=1 before) -> drop_cnt=1; exactly one later response discarded.
- Issue 32'h0010_0073 with one response outstanding -> halted=1 next cycle; no further requests; late response absorbed; redirect ignored; rstn low restores pc=8000_0000.
